// File: rtl/serial_ripple_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry, LSB first,
// one bit per clock. Operands enter through a valid/ready handshake and the
// result leaves through another; the arithmetic matches a parallel
// ripple-carry adder bit for bit.

module sra_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  // Counter only has to reach WIDTH-1; one spare bit keeps WIDTH=1 legal.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_sum;
  logic             r_carry, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_c, w_last;

  sra_full_adder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, one bit per RUN edge, flags on the last bit.
  // Result registers are left alone in DONE/IDLE so they stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          // New sum bit enters at the MSB; written as shifts so WIDTH=1 works
          r_sum   <= (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cout <= w_c;
            r_ovf  <= r_carry ^ w_c;  // carry into MSB xor carry out of MSB
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Bench for serial_ripple_adder (WIDTH=8): table vectors, busy/backpressure
// and mid-operation reset sequences, then random back-to-back traffic.

module tb_serial_ripple_adder;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  serial_ripple_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t        e;
    logic [W:0]  t;
    t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s  = t[W-1:0];
    e.co = t[W];
    e.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  // Called at a negedge: drive operands, wait for the accepting edge,
  // push the expected result, then drop in_valid at the next negedge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input exp_t e);
    int n = 0;
    a = x; b = y; cin = c; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, check latency and result, hold for 'hold' cycles
  // of backpressure, then release and check the return to IDLE.
  task automatic finish_op(input string name, input int hold);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, {63'd0, out_valid}, 64'd1);
    check({name, "_latency"}, 64'(cyc - acc_cyc), 64'(W));
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'd0, 64'd1);
      e = '{s: '0, co: 1'b0, ov: 1'b0};
    end else begin
      e = sb.pop_front();
    end
    check({name, "_sum"},  64'(sum),  64'(e.s));
    check({name, "_cout"}, 64'(cout), 64'(e.co));
    check({name, "_ovf"},  64'(ovf),  64'(e.ov));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check({name, "_hold_ready"}, {63'd0, in_ready},  64'd0);
      check({name, "_hold_sum"},   64'(sum),  64'(e.s));
      check({name, "_hold_flags"}, {62'd0, cout, ovf}, {62'd0, e.co, e.ov});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_idle_ready"}, {63'd0, in_ready},  64'd1);
    check({name, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  vec_t tbl[4];

  initial begin
    exp_t e;
    int   prev;
    logic [W-1:0] ra, rb;
    logic rc;

    tbl[0] = '{a: 8'h5A, b: 8'h3C, ci: 1'b0, s: 8'h96, co: 1'b0, ov: 1'b1};
    tbl[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
    tbl[3] = '{a: 8'h7F, b: 8'h00, ci: 1'b1, s: 8'h80, co: 1'b0, ov: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_result",    {55'd0, sum, cout}, 64'd0);
    check("rst_ovf",       {63'd0, ovf},       64'd0);

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      e = '{s: tbl[i].s, co: tbl[i].co, ov: tbl[i].ov};
      start_op(tbl[i].a, tbl[i].b, tbl[i].ci, e);
      check("tbl_busy", {63'd0, busy}, 64'd1);
      finish_op($sformatf("tbl%0d", i), 0);
    end

    // in_valid while busy is ignored; then 5 cycles of backpressure in DONE
    out_ready = 1'b0;
    start_op(8'h80, 8'h80, 1'b0, '{s: 8'h00, co: 1'b1, ov: 1'b1});
    a = 8'h01; b = 8'h01; cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("busy_in_ready", {63'd0, in_ready}, 64'd0);
      check("busy_flag",     {63'd0, busy},     64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish_op("bp", 5);

    // Reset at the 3rd RUN cycle aborts the operation
    start_op(8'h55, 8'h22, 1'b0, model(8'h55, 8'h22, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    check("abort_sum",      64'(sum),           64'd0);
    check("abort_in_ready", {63'd0, in_ready},  64'd1);
    check("abort_busy",     {63'd0, busy},      64'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 12; k++) begin
        if (out_valid) seen++;
        @(negedge clk);
      end
      check("abort_no_valid", 64'(seen), 64'd0);
    end
    start_op(8'h12, 8'h34, 1'b0, '{s: 8'h46, co: 1'b0, ov: 1'b0});
    finish_op("post_abort", 0);

    // Random back-to-back traffic with out_ready high
    prev = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      start_op(ra, rb, rc, model(ra, rb, rc));
      if (prev >= 0) check("rnd_spacing", 64'(acc_cyc - prev), 64'(W + 2));
      prev = acc_cyc;
      finish_op("rnd", 0);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
